// File: rtl/delay_commutator.sv
// Two-lane delay-switch-delay commutator for MDC FFT pipelines.
// Optional pass-through mode enabled by defining DELAY_COMMUTATOR_BYPASS_EN.
module delay_commutator #(
    parameter int unsigned DELAY = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
`ifdef DELAY_COMMUTATOR_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] x0_re,
    input  logic signed [WIDTH-1:0] x0_im,
    input  logic signed [WIDTH-1:0] x1_re,
    input  logic signed [WIDTH-1:0] x1_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] y0_re,
    output logic signed [WIDTH-1:0] y0_im,
    output logic signed [WIDTH-1:0] y1_re,
    output logic signed [WIDTH-1:0] y1_im
);

    localparam int unsigned CNT_W  = $clog2(2 * DELAY);
    localparam int unsigned SEL_B  = $clog2(DELAY);
    localparam int unsigned FILL_W = $clog2(DELAY + 1);
    localparam int unsigned CW     = 2 * WIDTH;

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ov_q,   ov_d;
    logic [CW-1:0]     y0_q,   y0_d;
    logic [CW-1:0]     y1_q,   y1_d;
    logic [CW-1:0]     d1_q [DELAY];
    logic [CW-1:0]     d1_d [DELAY];
    logic [CW-1:0]     d2_q [DELAY];
    logic [CW-1:0]     d2_d [DELAY];

    logic          byp_c;
    logic          primed;
    logic          sel;
    logic [CW-1:0] x0_c, x1_c, a1, s0, s1, d2;

`ifdef DELAY_COMMUTATOR_BYPASS_EN
    assign byp_c = bypass;
`else
    assign byp_c = 1'b0;
`endif

    // Swap network: re and im travel together as one packed lane word
    assign x0_c   = {x0_re, x0_im};
    assign x1_c   = {x1_re, x1_im};
    assign a1     = d1_q[DELAY-1];
    assign d2     = d2_q[DELAY-1];
    assign sel    = cnt_q[SEL_B];
    assign s0     = sel ? a1 : x0_c;
    assign s1     = sel ? x0_c : a1;
    assign primed = (fill_q == FILL_W'(DELAY));

    // Next state: clr wins over in_valid, bypass freezes the framing state
    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        ov_d   = 1'b0;
        y0_d   = y0_q;
        y1_d   = y1_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        if (clr) begin
            cnt_d  = '0;
            fill_d = '0;
        end else if (in_valid && byp_c) begin
            ov_d = 1'b1;
            y0_d = x0_c;
            y1_d = x1_c;
        end else if (in_valid) begin
            d1_d[0] = x1_c;
            d2_d[0] = s0;
            for (int i = 1; i < int'(DELAY); i++) begin
                d1_d[i] = d1_q[i-1];
                d2_d[i] = d2_q[i-1];
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (!primed) begin
                fill_d = fill_q + FILL_W'(1);
            end
            ov_d = primed;
            y0_d = d2;
            y1_d = s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fill_q <= '0;
            ov_q   <= 1'b0;
            y0_q   <= '0;
            y1_q   <= '0;
            d1_q   <= '{default: '0};
            d2_q   <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            ov_q   <= ov_d;
            y0_q   <= y0_d;
            y1_q   <= y1_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
        end
    end

    assign out_valid = ov_q;
    assign y0_re     = y0_q[CW-1:WIDTH];
    assign y0_im     = y0_q[WIDTH-1:0];
    assign y1_re     = y1_q[CW-1:WIDTH];
    assign y1_im     = y1_q[WIDTH-1:0];

endmodule

// File: tb/tb_delay_commutator.sv
// Scoreboard bench for delay_commutator: DELAY=2, DELAY=1 and DELAY=8 instances.
module tb_delay_commutator;

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] y0r, y0i, y1r, y1i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr [3];
    logic        iv  [3];
    logic [15:0] x0r [3], x0i [3], x1r [3], x1i [3];
    logic        ov  [3];
    logic [15:0] y0r [3], y0i [3], y1r [3], y1i [3];
`ifdef DELAY_COMMUTATOR_BYPASS_EN
    logic        byp [3];
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    delay_commutator #(.DELAY(2), .WIDTH(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
`ifdef DELAY_COMMUTATOR_BYPASS_EN
        .bypass(byp[0]),
`endif
        .in_valid(iv[0]), .x0_re(x0r[0]), .x0_im(x0i[0]), .x1_re(x1r[0]), .x1_im(x1i[0]),
        .out_valid(ov[0]), .y0_re(y0r[0]), .y0_im(y0i[0]), .y1_re(y1r[0]), .y1_im(y1i[0]));

    delay_commutator #(.DELAY(1), .WIDTH(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
`ifdef DELAY_COMMUTATOR_BYPASS_EN
        .bypass(byp[1]),
`endif
        .in_valid(iv[1]), .x0_re(x0r[1]), .x0_im(x0i[1]), .x1_re(x1r[1]), .x1_im(x1i[1]),
        .out_valid(ov[1]), .y0_re(y0r[1]), .y0_im(y0i[1]), .y1_re(y1r[1]), .y1_im(y1i[1]));

    delay_commutator #(.DELAY(8), .WIDTH(16)) u_d8 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]),
`ifdef DELAY_COMMUTATOR_BYPASS_EN
        .bypass(byp[2]),
`endif
        .in_valid(iv[2]), .x0_re(x0r[2]), .x0_im(x0i[2]), .x1_re(x1r[2]), .x1_im(x1i[2]),
        .out_valid(ov[2]), .y0_re(y0r[2]), .y0_im(y0i[2]), .y1_re(y1r[2]), .y1_im(y1i[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid output pair consumes one scoreboard entry
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out inst %0d got %h %h %h %h expected none at %0t",
                             i, y0r[i], y0i[i], y1r[i], y1i[i], $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_inst", 64'(i), 64'(e.inst));
                    chk("out_pair", {y0r[i], y0i[i], y1r[i], y1i[i]}, {e.y0r, e.y0i, e.y1r, e.y1i});
                end
            end
        end
    end

    task automatic step(input int i, input logic v,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        @(negedge clk);
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        iv[i]  = v;
        x0r[i] = a;
        x0i[i] = b;
        x1r[i] = c;
        x1i[i] = d;
    endtask

    task automatic push(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        exp_t e;
        e.inst = 2'(i);
        e.y0r  = a;
        e.y0i  = b;
        e.y1r  = c;
        e.y1i  = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic drain(input string name);
        idle(4);
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Hand-computed pairs for DELAY=2 with x0=k, x1=100+k, outputs from k=2
    int d2_y0 [8] = '{0, 1, 100, 101, 4, 5, 104, 105};
    int d2_y1 [8] = '{2, 3, 102, 103, 6, 7, 106, 107};
    // DELAY=1 with x0=k, x1=50+k, outputs from k=1
    int d1_y0 [5] = '{0, 50, 2, 52, 4};
    int d1_y1 [5] = '{1, 51, 3, 53, 5};

    task automatic send_d2(input int k);
        step(0, 1'b1, 16'(k), 16'(k), 16'(100 + k), 16'(100 + k));
        if (k >= 2) push(0, 16'(d2_y0[k-2]), 16'(d2_y0[k-2]), 16'(d2_y1[k-2]), 16'(d2_y1[k-2]));
    endtask

    initial begin
        logic [15:0] vn, vp, v0, v1;
        vn = 16'h8000;
        vp = 16'h7fff;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            clr[j] = 1'b0; iv[j] = 1'b0;
            x0r[j] = '0; x0i[j] = '0; x1r[j] = '0; x1i[j] = '0;
`ifdef DELAY_COMMUTATOR_BYPASS_EN
            byp[j] = 1'b0;
`endif
        end
        #1 rst_n = 1'b0;
        #2;
        for (int j = 0; j < 3; j++) begin
            chk("rst_ov", 64'(ov[j]), 64'd0);
            chk("rst_y0", {32'd0, y0r[j], y0i[j]}, 64'd0);
            chk("rst_y1", {32'd0, y1r[j], y1i[j]}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ordering, DELAY=2
        for (int k = 0; k < 10; k++) send_d2(k);
        drain("basic_drain");

        // Same stream with a 3-cycle stall after k=3
        do_reset;
        for (int k = 0; k < 4; k++) send_d2(k);
        idle(1);
        idle(1);
        chk("stall_ov2", 64'(ov[0]), 64'd0);
        idle(1);
        chk("stall_ov3", 64'(ov[0]), 64'd0);
        for (int k = 4; k < 10; k++) send_d2(k);
        drain("stall_drain");

        // Asynchronous reset mid-stream
        do_reset;
        for (int k = 0; k < 6; k++) send_d2(k);
        step(0, 1'b1, 16'd6, 16'd6, 16'd106, 16'd106);
        @(posedge clk);
        #2;
        chk("pre_rst_ov", 64'(ov[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(ov[0]), 64'd0);
        chk("mid_rst_y0", {32'd0, y0r[0], y0i[0]}, 64'd0);
        chk("mid_rst_y1", {32'd0, y1r[0], y1i[0]}, 64'd0);
        @(negedge clk);
        iv[0] = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send_d2(k);

        // clr with in_valid: sample dropped, framing restarts
        step(0, 1'b1, 16'd77, 16'd77, 16'd77, 16'd77);
        clr[0] = 1'b1;
        step(0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        clr[0] = 1'b0;
        chk("clr_ov", 64'(ov[0]), 64'd0);
        for (int k = 0; k < 6; k++) send_d2(k);
        drain("clr_drain");

        // DELAY=1
        do_reset;
        for (int k = 0; k < 6; k++) begin
            step(1, 1'b1, 16'(k), 16'(k), 16'(50 + k), 16'(50 + k));
            if (k >= 1) push(1, 16'(d1_y0[k-1]), 16'(d1_y0[k-1]), 16'(d1_y1[k-1]), 16'(d1_y1[k-1]));
        end
        drain("d1_drain");

        // DELAY=8 signed extremes, alternating per sample
        do_reset;
        for (int k = 0; k < 24; k++) begin
            v0 = (k % 2 == 1) ? vp : vn;
            v1 = (k % 2 == 1) ? vn : vp;
            step(2, 1'b1, v0, v1, v1, v0);
            if (k >= 8 && k < 16) push(2, v0, v1, v0, v1);
            if (k >= 16)          push(2, v1, v0, v1, v0);
        end
        drain("d8_drain");

`ifdef DELAY_COMMUTATOR_BYPASS_EN
        // Bypass pass-through, then reordering resumes from the held count
        do_reset;
        for (int k = 0; k < 3; k++) send_d2(k);
        idle(1);
        byp[0] = 1'b1;
        step(0, 1'b1, 16'd5, 16'd5, 16'hfff9, 16'hfff9);
        push(0, 16'd5, 16'd5, 16'hfff9, 16'hfff9);
        idle(1);
        byp[0] = 1'b0;
        for (int k = 3; k < 6; k++) send_d2(k);
        drain("byp_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
